// File: rtl/id_ctrl_issue_pkg.sv
// Shared definitions for the decode-stage control issuer and the downstream
// ID/EX (and later) control registers.
package id_ctrl_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ctrl_issue_decode.sv
// Pure combinational opcode-to-control-bundle table with rt-usage and
// illegal-opcode flags.
module ctrl_decode
    import id_ctrl_issue_pkg::*;
(
    input  logic [5:0]   opcode,
    output ctrl_bundle_t bundle,
    output logic         uses_rt,
    output logic         illegal
);

    always_comb begin
        bundle  = CTRL_BUBBLE;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                bundle.reg_dst   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.alu_op    = ALU_FUNCT;
                uses_rt          = 1'b1;
            end
            OP_LW: begin
                bundle.alu_src    = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.reg_write  = 1'b1;
                bundle.mem_read   = 1'b1;
                bundle.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
                bundle.alu_op    = ALU_ADD;
                uses_rt          = 1'b1;
            end
            OP_BEQ: begin
                bundle.branch = 1'b1;
                bundle.alu_op = ALU_SUB;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.alu_op    = ALU_ADD;
            end
            OP_J: begin
                bundle.jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_issue.sv
// Decode-stage control issuer: drives the ID/EX control bundle and PC/IF-ID
// enables, inserting bubbles for load-use hazards and redirect squash windows.
module id_ctrl_issue
    import id_ctrl_issue_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             redirect,
    output logic [1:0]       ALUOp,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t       state;
    logic [3:0]   flush_left;
    ctrl_bundle_t dec_bundle;
    ctrl_bundle_t out_bundle;
    logic         uses_rt;
    logic         dec_illegal;
    logic         hazard;

    ctrl_decode u_decode (
        .opcode  (opcode),
        .bundle  (dec_bundle),
        .uses_rt (uses_rt),
        .illegal (dec_illegal)
    );

    assign hazard = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

    // Mealy outputs: squash (FLUSH or a fresh redirect) beats hazard beats decode.
    always_comb begin
        out_bundle  = dec_bundle;
        illegal_op  = dec_illegal;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        if (state == ST_FLUSH || redirect) begin
            out_bundle  = CTRL_BUBBLE;
            illegal_op  = 1'b0;
            if_id_flush = 1'b1;
        end else if (hazard) begin
            out_bundle  = CTRL_BUBBLE;
            illegal_op  = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end
    end

    assign ALUOp    = out_bundle.alu_op;
    assign RegDst   = out_bundle.reg_dst;
    assign Branch   = out_bundle.branch;
    assign MemRead  = out_bundle.mem_read;
    assign MemtoReg = out_bundle.mem_to_reg;
    assign MemWrite = out_bundle.mem_write;
    assign ALUSrc   = out_bundle.alu_src;
    assign RegWrite = out_bundle.reg_write;
    assign jump     = out_bundle.jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            flush_left <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect) begin
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                        if (MULTI_FLUSH) begin
                            state      <= ST_FLUSH;
                            flush_left <= FLUSH_RELOAD;
                        end
                    end else if (hazard) begin
                        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        flush_left <= FLUSH_RELOAD;
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                    end else begin
                        flush_left <= flush_left - 4'd1;
                        if (flush_left == 4'd1) state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ctrl_issue.sv
// Self-checking bench for id_ctrl_issue (FLUSH_CYCLES=3, CNT_W=4).
module tb_id_ctrl_issue;

    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_memread, redirect;
    logic [1:0]    ALUOp;
    logic          RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump;
    logic          pc_write, if_id_write, if_id_flush, illegal_op;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: squashed cycles still owed after the current one, and event counts.
    int rem_m   = 0;
    int stall_m = 0;
    int flush_m = 0;

    id_ctrl_issue #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .redirect(redirect),
        .ALUOp(ALUOp), .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .jump(jump), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {ALUOp[1:0],RegDst,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,jump,illegal,pcw,ifw,flush}
    function automatic logic [13:0] outs();
        return {ALUOp, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
                RegWrite, jump, illegal_op, pc_write, if_id_write, if_id_flush};
    endfunction

    function automatic logic [9:0] dec_ref(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b10_1_0_0_0_0_0_1_0;
            6'h23:   return 10'b00_0_0_1_1_0_1_1_0;
            6'h2B:   return 10'b00_0_0_0_0_1_1_0_0;
            6'h04:   return 10'b01_0_1_0_0_0_0_0_0;
            6'h08:   return 10'b00_0_0_0_0_0_1_1_0;
            6'h02:   return 10'b00_0_0_0_0_0_0_0_1;
            default: return 10'b0;
        endcase
    endfunction

    function automatic bit legal_ref(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic bit hazard_ref();
        bit reads_rt = opcode inside {6'h00, 6'h2B, 6'h04};
        return ex_memread && ex_rt != 0 &&
               (ex_rt == id_rs || (reads_rt && ex_rt == id_rt));
    endfunction

    function automatic logic [13:0] expect_ref();
        if (rem_m > 0 || redirect) return {10'b0, 4'b0111};
        if (hazard_ref())          return {10'b0, 4'b0000};
        return {dec_ref(opcode), !legal_ref(opcode), 3'b110};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (redirect) begin
            flush_m = (flush_m < CMAX) ? flush_m + 1 : CMAX;
            rem_m   = FC - 1;
        end else if (rem_m > 0) begin
            rem_m--;
        end else if (hazard_ref()) begin
            stall_m = (stall_m < CMAX) ? stall_m + 1 : CMAX;
        end
    endtask

    // Check outputs mid-cycle, then advance one edge and update the model.
    task automatic step(input string name);
        @(negedge clk);
        check({name, "_outs"}, int'(outs()), int'(expect_ref()));
        @(posedge clk);
        model_edge();
        #1;
        check({name, "_stall"}, int'(stall_cnt), stall_m);
        check({name, "_flush"}, int'(flush_cnt), flush_m);
    endtask

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic mr, input logic [4:0] xrt, input logic rd);
        opcode = op; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = xrt; redirect = rd;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic        mr;
        logic [4:0]  xrt;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Reset asserted from time zero: RUN decode of R-type with counters cleared.
        rst = 1'b0;
        set_in(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        #3;
        check("reset_outs", int'(outs()), int'({10'b10_1_0_0_0_0_0_1_0, 4'b0110}));
        check("reset_stall", int'(stall_cnt), 0);
        check("reset_flush", int'(flush_cnt), 0);
        #9 rst = 1'b1;

        vecs.push_back('{6'h00, 5'd1, 5'd2, 1'b0, 5'd0, {10'b10_1_0_0_0_0_0_1_0, 4'b0110}});
        vecs.push_back('{6'h23, 5'd1, 5'd2, 1'b0, 5'd0, {10'b00_0_0_1_1_0_1_1_0, 4'b0110}});
        vecs.push_back('{6'h2B, 5'd1, 5'd2, 1'b0, 5'd0, {10'b00_0_0_0_0_1_1_0_0, 4'b0110}});
        vecs.push_back('{6'h04, 5'd1, 5'd2, 1'b0, 5'd0, {10'b01_0_1_0_0_0_0_0_0, 4'b0110}});
        vecs.push_back('{6'h08, 5'd1, 5'd2, 1'b0, 5'd0, {10'b00_0_0_0_0_0_1_1_0, 4'b0110}});
        vecs.push_back('{6'h02, 5'd1, 5'd2, 1'b0, 5'd0, {10'b00_0_0_0_0_0_0_0_1, 4'b0110}});
        vecs.push_back('{6'h3F, 5'd1, 5'd2, 1'b0, 5'd0, {10'b0, 4'b1110}});
        // addi does not read rt, so an rt match is not a hazard
        vecs.push_back('{6'h08, 5'd1, 5'd7, 1'b1, 5'd7, {10'b00_0_0_0_0_0_1_1_0, 4'b0110}});
        vecs.push_back('{6'h2B, 5'd1, 5'd7, 1'b1, 5'd7, {10'b0, 4'b0000}});
        vecs.push_back('{6'h00, 5'd5, 5'd2, 1'b1, 5'd0, {10'b10_1_0_0_0_0_0_1_0, 4'b0110}});
        vecs.push_back('{6'h3F, 5'd5, 5'd2, 1'b1, 5'd5, {10'b0, 4'b0000}});

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            set_in(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].xrt, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
            @(posedge clk);
            model_edge();
            #1;
        end
        check("vec_stall", int'(stall_cnt), 2);

        // Load-use: single bubble, then decode resumes; ex_rt=0 never stalls.
        set_in(6'h00, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0);
        @(negedge clk);
        check("lu_pcw", int'(pc_write), 0);
        check("lu_ifw", int'(if_id_write), 0);
        @(posedge clk); model_edge(); #1;
        check("lu_stall", int'(stall_cnt), 3);
        ex_memread = 1'b0;
        step("lu_resume");
        check("lu_resume_pcw", int'(pc_write), 1);
        set_in(6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_zero");
        check("lu_zero_stall", int'(stall_cnt), 3);

        // Redirect window: three squashed cycles, then decode.
        set_in(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("win_flush%0d", c), int'(if_id_flush), (c < 3) ? 1 : 0);
            check($sformatf("win_regdst%0d", c), int'(RegDst), (c < 3) ? 0 : 1);
            @(posedge clk); model_edge(); #1;
            redirect = 1'b0;
        end
        check("win_fcnt", int'(flush_cnt), 1);

        // Second redirect in the 2nd flush cycle extends squash by two more cycles.
        redirect = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("ext_flush%0d", c), int'(if_id_flush), (c < 4) ? 1 : 0);
            @(posedge clk); model_edge(); #1;
            redirect = (c == 0);
        end
        check("ext_fcnt", int'(flush_cnt), 3);

        // Redirect and hazard together: redirect wins, no stall counted.
        set_in(6'h00, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1);
        @(negedge clk);
        check("sim_pcw", int'(pc_write), 1);
        check("sim_flush", int'(if_id_flush), 1);
        @(posedge clk); model_edge(); #1;
        check("sim_stall", int'(stall_cnt), 3);
        check("sim_fcnt", int'(flush_cnt), 4);

        // Asynchronous reset while in FLUSH.
        set_in(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rstf_outs", int'(outs()), int'({10'b10_1_0_0_0_0_0_1_0, 4'b0110}));
        check("rstf_stall", int'(stall_cnt), 0);
        check("rstf_fcnt", int'(flush_cnt), 0);
        rem_m = 0; stall_m = 0; flush_m = 0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        step("post_rst");

        // Saturation: 20 separate load-use stalls.
        for (int n = 0; n < 20; n++) begin
            set_in(6'h2B, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0);
            step("sat_hz");
            ex_memread = 1'b0;
            step("sat_gap");
        end
        check("sat_final", int'(stall_cnt), 15);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04;
                4: op = 6'h08; 5: op = 6'h02; default: op = 6'($urandom);
            endcase
            set_in(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ctrl_issue.md
# id_ctrl_issue

Decode-stage control issuer: the producer side of the ID/EX control bundle. Decodes the ID-stage opcode into the nine control fields that the ID/EX control register latches, and inserts bubbles for load-use hazards and branch/jump redirects. A small FSM squashes wrong-path instructions for a configurable window. Saturating stall/flush counters provide performance visibility. Sits between the IF/ID register and the ID/EX control register; also drives PC and IF/ID enables.

## Interface
- FLUSH_CYCLES, 2, ID-stage cycles squashed per redirect, including the redirect cycle; legal range 1..15.
- CNT_W, 16, width of the performance counters.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- opcode  in  6  ID-stage instr[31:26].
- id_rs, id_rt  in  5 each  ID-stage source register fields.
- ex_memread  in  1  MemRead currently held in ID/EX.
- ex_rt  in  5  rt of the instruction currently in ID/EX.
- redirect  in  1  branch taken or jump resolved this cycle.
- ALUOp  out  2  ALU operation class.
- RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, jump  out  1 each  control bundle to ID/EX.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  clear IF/ID.
- illegal_op  out  1  opcode not decodable, in RUN only.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- Decode (combinational):
  - 0x00 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 0x23 lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - 0x2B sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 0x04 beq: Branch=1, ALUOp=01.
  - 0x08 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x02 j: jump=1.
  - Any other opcode: all-zero bundle; illegal_op=1.
- Unlisted bundle fields are 0 for each opcode.
- uses_rt = R-type, sw, or beq.
- hazard = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
- Bubble: all-zero bundle; illegal_op=0.
- FSM states: RUN and FLUSH. A 4-bit flush_left counter accompanies the FSM.
- RUN:
  - redirect=1 (takes priority over hazard): bubble; if_id_flush=1; pc_write=1; if_id_write=1; flush_cnt+1. If FLUSH_CYCLES>1, go to FLUSH with flush_left=FLUSH_CYCLES-1; otherwise stay in RUN.
  - hazard=1 and no redirect: bubble; pc_write=0; if_id_write=0; stall_cnt+1; stay in RUN. The bubble clears ex_memread, so the stall lasts exactly one cycle.
  - Otherwise: pass the decoded bundle; pc_write=1; if_id_write=1; if_id_flush=0.
- FLUSH:
  - Outputs: bubble; if_id_flush=1; pc_write=1; if_id_write=1. Hazards are ignored and not counted.
  - redirect=1: reload flush_left=FLUSH_CYCLES-1; flush_cnt+1.
  - Otherwise: decrement flush_left; go to RUN when flush_left==1 at the clock edge.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Outputs are Mealy: a combinational path runs from opcode/ex_*/redirect to the bundle and enables. State, flush_left and counters are registered.
- Reset (rst=0), asynchronous at any time including mid-FLUSH:
  - State=RUN, flush_left=0, stall_cnt=0, flush_cnt=0.
  - Outputs then follow RUN decode of the current inputs.
- After release of reset, the first posedge updates state normally.
- Redirect in RUN: FLUSH_CYCLES consecutive squashed cycles, the redirect cycle being the first.
- Load-use: exactly 1 bubble cycle; the instruction held in IF/ID re-decodes in the next cycle.
- Simultaneous redirect and hazard: the redirect wins; stall_cnt is unchanged.

## Structure
- Shared package holds:
  - Opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUOp encodings: ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10.
  - FSM state encoding: ST_RUN, ST_FLUSH.
  - Control-bundle struct/typedef, reused by the ID/EX and later control registers.
- One sub-module, ctrl_decode: a pure combinational opcode-to-bundle table plus uses_rt and illegal outputs. The FSM, hazard compare and counters stay in the top level.

## Test plan
- Reset mid-FLUSH: drive rst=0 while in FLUSH with opcode 0x00. Required: state RUN, both counters 0, RegDst=1, RegWrite=1, ALUOp=10, pc_write=1.
- Decode sweep:
  - 0x23 gives ALUSrc, MemtoReg, RegWrite and MemRead all 1, ALUOp=00.
  - 0x2B gives MemWrite=1 and RegWrite=0.
  - 0x3F gives an all-zero bundle and illegal_op=1.
- Load-use: ex_memread=1, ex_rt=5, opcode 0x00, id_rs=5. Required: one bubble cycle with pc_write=0 and if_id_write=0, stall_cnt 0→1. Repeat with ex_rt=0: no stall.
- Redirect window (FLUSH_CYCLES=3): pulse redirect for one cycle. Required: bubble and if_id_flush=1 for 3 cycles, then decode resumes; flush_cnt=1. A second redirect in the 2nd flush cycle extends squashing by 2 more cycles, and flush_cnt=2.
- Simultaneous events: redirect=1 with a load-use hazard present. Required: pc_write=1, if_id_flush=1, stall_cnt unchanged, flush_cnt+1.
- Saturation (CNT_W=4): 20 separate load-use stalls. Required: stall_cnt reaches 15 and holds there.
